nested_loop_counter: RTL
========================

# nested_loop_counter

Runtime-programmable, multi-level loop counter: DEPTH digit counters chained by carry, each with its own bound latched at start, counting up or down. It supersedes fixed-N single-level counters in the MNIST datapath, driving row/column/channel iteration for convolution and dense-layer address generation. A start/busy/done handshake frames each full pass through the loop nest.

## Interface
- DEPTH, 3: number of loop levels; level 0 is innermost and fastest.
- W, 8: bits per level count and bound.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a pass; sampled only in IDLE.
- down  in  1  direction for the pass; latched with start (0 up, 1 down).
- bound_in  in  DEPTH*W  per-level bound; level i in bits [i*W +: W]; latched with start.
- en  in  1  advance the nest by one step; honoured only in RUN.
- abort  in  1  synchronous cancel of a pass; returns to IDLE.
- count  out  DEPTH*W  current per-level counts, packed like bound_in.
- last  out  DEPTH  level i is at its terminal value (up: bound−1; down: 0).
- wrap  out  DEPTH  one-cycle pulse: level i wrapped on the preceding clock edge.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final step of a pass.

## Operation
- States: IDLE, RUN. Reset: IDLE; count, wrap, done, busy = 0; latched bounds = 0; down latch = 0.
- IDLE + start: latch bound_in and down. Load level i with 0 (up) or bound_i−1 (down). Enter RUN.
- Bound value 0 means 2^W. Bound 1 means level i is permanently last, and it wraps on every carry-in.
- RUN + en: level 0 steps. Level i steps when en and last[0..i−1] are all 1. A stepping level that is last reloads its start value and pulses wrap[i].
- Final step: en with all last bits 1. All levels wrap, done pulses, busy falls, and the state returns to IDLE. Counts hold their start values: 0 for up, bound−1 for down.
- RUN + en=0: counts hold; no pulses.
- abort has priority over en and start. abort in RUN: go to IDLE and zero all counts; no done, no wrap. abort in IDLE: no effect beyond holding zeros.
- start while in RUN is ignored, as are changes to bound_in or down.
- rst mid-pass: immediate return to the reset state; no done.
- Arithmetic: each level is W-bit modular. Bound comparison uses bound−1 computed in W bits, so 0−1 = 2^W−1 yields bound 2^W.

## Timing
- start→busy: 1 cycle. The first count value is visible the same cycle busy rises.
- en→count update: 1 cycle (registered). last is combinational from registered count and latched bounds, valid the same cycle as count.
- wrap and done are registered and assert the cycle after the causing en edge, coincident with the new count.
- done and busy fall are coincident. A new start is accepted the cycle after done, which allows back-to-back passes.
- Steps per pass = product of effective bounds. The done pulse follows the step whose count was all-terminal.

## Structure
- Package mnist_ctr_pkg holds:
  - typedef enum logic {IDLE, RUN} nlc_state_t
  - helper function term_val(bound, down)
- Sub-module counter_level holds one digit. Ports: clk, rst, load, load_val, step, down, bound_m1, count, last, wrap. The top instantiates DEPTH of them in a generate loop, ANDing last bits into a carry chain.
- The top owns the FSM, the bound/direction latches, and done/busy.

## Test plan
- Reset then idle: rst pulse with en=1, start=0 → count=0, busy=0, no wrap/done for 20 cycles.
- Up pass: DEPTH=3, bounds {3,2,4} (L2,L1,L0), en held 1 → 24 steps. Check:
  - wrap[0] every 4 steps, wrap[1] every 8, wrap[2] once.
  - done on the 24th step's following cycle, then busy=0.
- Down pass with gaps: bounds {2,2,2}, down=1, en toggled 1/0 → counts start at {1,1,1} and decrement only on en cycles. done arrives after 8 en-cycles, and counts return to {1,1,1}.
- Edge bounds: L0 bound 1, L1 bound 0 (=256 at W=8) → wrap[0] every step; L1 reaches 255 and then wraps. Total steps = 256×L2 bound.
- Abort and ignored start: abort mid-pass → IDLE next cycle, count=0, no done. start+new bounds while busy → no effect on the running count sequence.
- Back-to-back: start asserted the cycle after done → second pass runs with the newly latched bounds and no idle gap beyond 1 cycle.

Source files
------------

// File: rtl/mnist_ctr_pkg.sv
// Shared types and helpers for the MNIST loop-nest address counters.
package mnist_ctr_pkg;

  typedef enum logic {IDLE, RUN} nlc_state_t;

  // Terminal value of a level: bound-1 counting up, 0 counting down.
  // Computed at 32 bits; callers truncate to their width, so a bound of 0
  // becomes all-ones (an effective bound of 2^W).
  function automatic logic [31:0] term_val(input logic [31:0] bound, input logic down);
    return down ? '0 : (bound - 32'd1);
  endfunction

endpackage

// File: rtl/counter_level.sv
// One digit of the loop nest: modular up/down counter with reload-on-wrap.
module counter_level #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         down,
  input  logic [W-1:0] bound_m1,
  output logic [W-1:0] count,
  output logic         last,
  output logic         wrap
);

  assign last = down ? (count == '0) : (count == bound_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      wrap  <= 1'b0;
    end else if (step) begin
      if (last) begin
        count <= down ? bound_m1 : '0;
        wrap  <= 1'b1;
      end else begin
        count <= down ? (count - W'(1)) : (count + W'(1));
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/nested_loop_counter.sv
// Multi-level loop counter: DEPTH carry-chained digits with per-pass bounds,
// framed by a start/busy/done handshake.
module nested_loop_counter #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               down,
  input  logic [DEPTH*W-1:0] bound_in,
  input  logic               en,
  input  logic               abort,
  output logic [DEPTH*W-1:0] count,
  output logic [DEPTH-1:0]   last,
  output logic [DEPTH-1:0]   wrap,
  output logic               busy,
  output logic               done
);
  import mnist_ctr_pkg::*;

  nlc_state_t         state, state_nxt;
  logic [DEPTH*W-1:0] bound_q;
  logic               down_q;
  logic [DEPTH:0]     carry;
  logic               all_last;
  logic               load, load_zero, run_step;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start && !abort) state_nxt = RUN;
      RUN:  if (abort || (en && all_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    load      = 1'b0;
    load_zero = 1'b0;
    run_step  = 1'b0;
    unique case (state)
      IDLE: load = start & ~abort;
      RUN: begin
        busy      = 1'b1;
        load      = abort;
        load_zero = abort;
        run_step  = en & ~abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bound_q <= '0;
      down_q  <= 1'b0;
    end else if (state == IDLE && start && !abort) begin
      bound_q <= bound_in;
      down_q  <= down;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) done <= 1'b0;
    else     done <= run_step & all_last;
  end

  assign carry[0] = 1'b1;
  assign all_last = carry[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_lvl
    logic [W-1:0] start_val, bound_m1, load_val;

    // The start value of a direction is the terminal value of the opposite one.
    assign start_val = W'(term_val(32'(bound_in[i*W +: W]), !down));
    assign bound_m1  = bound_q[i*W +: W] - W'(1);
    assign load_val  = load_zero ? '0 : start_val;
    assign carry[i+1] = carry[i] & last[i];

    counter_level #(.W(W)) u_lvl (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .step     (run_step & carry[i]),
      .down     (down_q),
      .bound_m1 (bound_m1),
      .count    (count[i*W +: W]),
      .last     (last[i]),
      .wrap     (wrap[i])
    );
  end

endmodule
